chacha_xor_stream: RTL and testbench

Downstream consumer of the 32-bit keystream serialiser in the ChaCha20-Poly1305 datapath. Buffers serialised keystream words in a FIFO, requests new 64-byte keystream blocks from the block-function/serialiser pair as space allows, and XORs each buffered word with an incoming plaintext (or ciphertext) word stream under valid/ready handshakes. The output stream feeds the Poly1305 MAC and the external data port. Each message starts from a caller-supplied block counter, and any keystream left over at message end is discarded.

---
 rtl/chacha_xor_stream_if.sv | 26 ++
 rtl/chacha_xor_stream.sv | 163 ++++++++++++++++
 tb/tb_chacha_xor_stream.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/chacha_xor_stream_if.sv
// Data stream bundle for chacha_xor_stream.
//   din/din_keep/din_last/din_valid/din_ready : plaintext or ciphertext input
//   dout/dout_keep/dout_last/dout_valid/dout_ready : XOR result output
// master: data source and sink side; slave: the XOR block.
interface chacha_xor_stream_if;
  logic [31:0] din;
  logic [3:0]  din_keep;
  logic        din_last;
  logic        din_valid;
  logic        din_ready;
  logic [31:0] dout;
  logic [3:0]  dout_keep;
  logic        dout_last;
  logic        dout_valid;
  logic        dout_ready;

  modport master (
    output din, din_keep, din_last, din_valid, dout_ready,
    input  din_ready, dout, dout_keep, dout_last, dout_valid
  );

  modport slave (
    input  din, din_keep, din_last, din_valid, dout_ready,
    output din_ready, dout, dout_keep, dout_last, dout_valid
  );
endinterface

// File: rtl/chacha_xor_stream.sv
// Keystream buffer and XOR stage of the ChaCha20-Poly1305 datapath.
// Buffers serialised keystream words, requests 16-word blocks while space
// allows, and XORs each buffered word into the data stream.
//   clk, rst          : clock, synchronous active-high reset
//   start, ctr_init   : begin a message from block counter ctr_init
//   blk_req, blk_ctr  : one-cycle block request and its counter
//   ks_word, ks_valid : keystream from the serialiser (no backpressure)
//   io                : din/dout valid-ready data streams
//   done              : pulse when a message has fully flushed
//   ks_ovf            : sticky keystream overflow flag
module chacha_xor_stream #(
  parameter int unsigned FIFO_DEPTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [31:0]        ctr_init,
  output logic               blk_req,
  output logic [31:0]        blk_ctr,
  input  logic [31:0]        ks_word,
  input  logic               ks_valid,
  chacha_xor_stream_if.slave io,
  output logic               done,
  output logic               ks_ovf
);
  localparam int unsigned AW        = $clog2(FIFO_DEPTH);
  localparam int unsigned CW        = AW + 1;
  localparam int unsigned BLK_WORDS = 16;
  localparam int unsigned IW        = 5;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2} state_t;

  state_t        state;
  state_t        state_d;
  logic [31:0]   ctr;
  logic [IW-1:0] inflight;
  logic [CW-1:0] wr_ptr;
  logic [CW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] free;
  logic [31:0]   mem [FIFO_DEPTH];
  logic          fifo_nonempty;
  logic          fifo_full;
  logic          fifo_clr;
  logic          msg_start;
  logic          push;
  logic          pop;
  logic [31:0]   keep_mask;
  logic [31:0]   ks_head;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign count         = wr_ptr - rd_ptr;
  assign free          = CW'(FIFO_DEPTH) - count;
  assign fifo_nonempty = (count != '0);
  assign fifo_full     = (count == CW'(FIFO_DEPTH));
  assign ks_head       = mem[rd_ptr[AW-1:0]];
  assign blk_ctr       = ctr;

  assign pop  = io.din_valid && io.din_ready;
  // Keystream is only kept in RUN; a full FIFO drops the word rather than overwrite.
  assign push = (state == RUN) && ks_valid && !fifo_full;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (pop && io.din_last) state_d = FLUSH;
      FLUSH:   if (done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Per-state outputs and datapath strobes
  always_comb begin
    blk_req      = 1'b0;
    io.din_ready = 1'b0;
    done         = 1'b0;
    fifo_clr     = 1'b0;
    msg_start    = 1'b0;
    case (state)
      IDLE: begin
        msg_start = start;
        fifo_clr  = start;
      end
      RUN: begin
        // One block outstanding at most, and only when it fits entirely.
        blk_req      = (inflight == '0) && (free >= CW'(BLK_WORDS));
        io.din_ready = fifo_nonempty && (!io.dout_valid || io.dout_ready);
      end
      FLUSH: begin
        fifo_clr = 1'b1;
        done     = (inflight == '0) && (!io.dout_valid || io.dout_ready);
      end
      default: ;
    endcase
    // Reset aborts the message without a request, transfer or done pulse.
    if (rst) begin
      blk_req      = 1'b0;
      io.din_ready = 1'b0;
      done         = 1'b0;
    end
  end

  // Byte-lane mask from din_keep
  always_comb begin
    keep_mask = '0;
    for (int j = 0; j < 4; j++) keep_mask[8*j +: 8] = {8{io.din_keep[j]}};
  end

  // Keystream storage
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= ks_word;
  end

  // Counter, in-flight tracking, FIFO pointers and output register
  always_ff @(posedge clk) begin
    if (rst) begin
      ctr           <= '0;
      inflight      <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      ks_ovf        <= 1'b0;
      io.dout       <= '0;
      io.dout_keep  <= '0;
      io.dout_last  <= 1'b0;
      io.dout_valid <= 1'b0;
    end else begin
      if (msg_start)    ctr <= ctr_init;
      else if (blk_req) ctr <= ctr + 32'd1;

      // Saturate at zero so unrequested keystream cannot underflow the count.
      if (msg_start)                             inflight <= '0;
      else if (blk_req)                          inflight <= IW'(BLK_WORDS);
      else if (ks_valid && (inflight != '0))     inflight <= inflight - IW'(1);

      if (fifo_clr) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + CW'(1);
        if (pop)  rd_ptr <= rd_ptr + CW'(1);
      end

      if ((state == RUN) && ks_valid && fifo_full) ks_ovf <= 1'b1;

      if (pop) begin
        io.dout       <= (io.din ^ ks_head) & keep_mask;
        io.dout_keep  <= io.din_keep;
        io.dout_last  <= io.din_last;
        io.dout_valid <= 1'b1;
      end else if (io.dout_ready) begin
        io.dout_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_chacha_xor_stream.sv
// Self-checking bench for chacha_xor_stream: serialiser model, scoreboard
// sink, table-driven single-word messages and multi-cycle scenarios.
module tb_chacha_xor_stream;
  localparam int unsigned DEPTH = 32;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } exp_t;

  typedef struct {
    logic [31:0] din;
    logic [3:0]  keep;
    logic [31:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] ctr_init;
  logic        blk_req;
  logic [31:0] blk_ctr;
  logic [31:0] ks_word;
  logic        ks_valid;
  logic        done;
  logic        ks_ovf;

  chacha_xor_stream_if dif ();

  chacha_xor_stream #(.FIFO_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .ctr_init (ctr_init),
    .blk_req  (blk_req),
    .blk_ctr  (blk_ctr),
    .ks_word  (ks_word),
    .ks_valid (ks_valid),
    .io       (dif.slave),
    .done     (done),
    .ks_ovf   (ks_ovf)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  exp_t        sb[$];
  logic [31:0] pend[$];
  logic [31:0] req_log[$];
  logic        sink_stall = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Keystream word k of block c; block 1 is 0..15 so the basic case is easy to read.
  function automatic logic [31:0] ks_fn(input logic [31:0] c, input int k);
    if (c == 32'd1) return 32'(k);
    return 32'hA5A5_A5A5 ^ {c[15:0], 16'h0000} ^ 32'(k);
  endfunction

  function automatic logic [31:0] keep_mask(input logic [3:0] k);
    logic [31:0] m;
    for (int j = 0; j < 4; j++) m[8*j +: 8] = k[j] ? 8'hFF : 8'h00;
    return m;
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] c0, input int i,
                                           input logic [31:0] d, input logic [3:0] k);
    return (d ^ ks_fn(c0 + 32'(i / 16), i % 16)) & keep_mask(k);
  endfunction

  // Serialiser: answers each request with 16 words, one per cycle.
  initial begin : serialiser
    ks_valid = 1'b0;
    ks_word  = '0;
    forever begin
      @(negedge clk);
      if (pend.size() > 0) begin
        ks_word  = pend.pop_front();
        ks_valid = 1'b1;
      end else begin
        ks_valid = 1'b0;
      end
      #1;
      if (!rst && blk_req) begin
        req_log.push_back(blk_ctr);
        for (int k = 0; k < 16; k++) pend.push_back(ks_fn(blk_ctr, k));
      end
    end
  end

  // Sink: compares every accepted output word against the scoreboard.
  initial begin : sink
    logic        was_stalled;
    logic [31:0] held_d;
    exp_t        e;
    was_stalled    = 1'b0;
    held_d         = '0;
    dif.dout_ready = 1'b0;
    forever begin
      @(negedge clk);
      dif.dout_ready = !sink_stall;
      #1;
      if (rst) begin
        was_stalled = 1'b0;
      end else begin
        if (was_stalled) begin
          chk("dout_hold", dif.dout, held_d);
          chk("dout_valid_hold", 32'(dif.dout_valid), 32'd1);
        end
        if (dif.dout_valid && !dif.dout_ready)
          chk("din_ready_stall", 32'(dif.din_ready), 32'd0);
        if (dif.dout_valid && dif.dout_ready) begin
          if (sb.size() == 0) begin
            chk("unexpected_dout", 32'(dif.dout_valid), 32'd0);
          end else begin
            e = sb.pop_front();
            chk("dout", dif.dout, e.d);
            chk("dout_keep", 32'(dif.dout_keep), 32'(e.k));
            chk("dout_last", 32'(dif.dout_last), 32'(e.l));
          end
        end
        was_stalled = dif.dout_valid && !dif.dout_ready;
        held_d      = dif.dout;
      end
    end
  end

  task automatic start_msg(input logic [31:0] c);
    @(negedge clk);
    start    = 1'b1;
    ctr_init = c;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("blk_req_first", 32'(blk_req), 32'd1);
  endtask

  task automatic drive_word(input logic [31:0] d, input logic [3:0] k, input logic l,
                            input logic [31:0] e);
    int n;
    n = 0;
    @(negedge clk);
    dif.din       = d;
    dif.din_keep  = k;
    dif.din_last  = l;
    dif.din_valid = 1'b1;
    #1;
    while (!dif.din_ready && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (dif.din_ready) sb.push_back('{d: e, k: k, l: l});
    else chk("din_ready_timeout", 32'(dif.din_ready), 32'd1);
  endtask

  task automatic end_din();
    @(negedge clk);
    dif.din_valid = 1'b0;
    dif.din_last  = 1'b0;
  endtask

  task automatic wait_done(input string name, input bit chk_pend);
    int n;
    bit seen;
    n = 0;
    #1;
    seen = done;
    while (!seen && n < 300) begin
      @(negedge clk);
      #1;
      seen = done;
      n++;
    end
    chk({name, "_done"}, 32'(seen), 32'd1);
    if (seen && chk_pend) chk({name, "_ks_drained"}, 32'(pend.size()), 32'd0);
    @(negedge clk);
    #1;
    chk({name, "_done_pulse"}, 32'(done), 32'd0);
    chk({name, "_idle_ready"}, 32'(dif.din_ready), 32'd0);
    #1;
    chk({name, "_sb_empty"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_blk_req"}, 32'(blk_req), 32'd0);
    chk({name, "_blk_ctr"}, blk_ctr, 32'd0);
    chk({name, "_din_ready"}, 32'(dif.din_ready), 32'd0);
    chk({name, "_dout"}, dif.dout, 32'd0);
    chk({name, "_dout_keep"}, 32'(dif.dout_keep), 32'd0);
    chk({name, "_dout_last"}, 32'(dif.dout_last), 32'd0);
    chk({name, "_dout_valid"}, 32'(dif.dout_valid), 32'd0);
    chk({name, "_done"}, 32'(done), 32'd0);
    chk({name, "_ks_ovf"}, 32'(ks_ovf), 32'd0);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t        tbl[6];
    int          base;
    bit          seen;
    logic [31:0] d;

    // Single-word messages from counter 0: keystream word 0 is 0xA5A5A5A5.
    tbl[0] = '{din: 32'h1234_5678, keep: 4'b0011, exp: 32'h0000_F3DD};
    tbl[1] = '{din: 32'h1234_5678, keep: 4'b1111, exp: 32'hB791_F3DD};
    tbl[2] = '{din: 32'hFFFF_FFFF, keep: 4'b1000, exp: 32'h5A00_0000};
    tbl[3] = '{din: 32'h0000_0000, keep: 4'b0101, exp: 32'h00A5_00A5};
    tbl[4] = '{din: 32'h5A5A_5A5A, keep: 4'b1111, exp: 32'hFFFF_FFFF};
    tbl[5] = '{din: 32'hA5A5_A5A5, keep: 4'b0000, exp: 32'h0000_0000};

    rst           = 1'b1;
    start         = 1'b0;
    ctr_init      = '0;
    dif.din       = '0;
    dif.din_keep  = '0;
    dif.din_last  = 1'b0;
    dif.din_valid = 1'b0;

    repeat (3) @(negedge clk);
    #2;
    chk_reset_outputs("rst");
    @(negedge clk);
    rst = 1'b0;

    // Basic XOR over one block, counter 1.
    base = req_log.size();
    start_msg(32'd1);
    for (int i = 0; i < 16; i++)
      drive_word(32'hFFFF_FFFF, 4'hF, (i == 15), 32'hFFFF_FFFF ^ 32'(i));
    end_din();
    wait_done("basic", 1'b0);
    chk("basic_nreq", 32'(req_log.size() - base), 32'd2);
    if (req_log.size() >= base + 2) begin
      chk("basic_req1", req_log[base], 32'd1);
      chk("basic_req2", req_log[base + 1], 32'd2);
    end

    // Table: single partial/full words with last; remaining keystream flushed.
    for (int v = 0; v < 6; v++) begin
      base = req_log.size();
      start_msg(32'd0);
      drive_word(tbl[v].din, tbl[v].keep, 1'b1, tbl[v].exp);
      end_din();
      wait_done($sformatf("vec%0d", v), 1'b1);
      chk($sformatf("vec%0d_nreq", v), 32'(req_log.size() - base), 32'd1);
    end

    // Backpressure: 5-cycle downstream stall mid-stream across two blocks.
    start_msg(32'h0000_0100);
    fork
      for (int i = 0; i < 20; i++) begin
        logic [31:0] w;
        logic [3:0]  k;
        w = (32'(i) * 32'h0101_0101) ^ 32'h3C00_00C3;
        k = (i == 19) ? 4'b1001 : 4'hF;
        drive_word(w, k, (i == 19), exp_word(32'h0000_0100, i, w, k));
      end
      begin
        repeat (8) @(negedge clk);
        #3 sink_stall = 1'b1;
        repeat (5) @(negedge clk);
        #3 sink_stall = 1'b0;
      end
    join
    end_din();
    wait_done("bp", 1'b0);

    // Flush: last on word 3 while 12 keystream words are still arriving.
    base = req_log.size();
    start_msg(32'd5);
    for (int i = 0; i < 4; i++) begin
      d = 32'hC0DE_0000 + 32'(i);
      drive_word(d, 4'hF, (i == 3), exp_word(32'd5, i, d, 4'hF));
    end
    end_din();
    wait_done("flush", 1'b1);
    chk("flush_nreq", 32'(req_log.size() - base), 32'd1);
    start_msg(32'd1);
    #1;
    chk("flush_next_empty", 32'(dif.din_ready), 32'd0);
    for (int i = 0; i < 2; i++)
      drive_word(32'h0F0F_0F0F, 4'hF, (i == 1), 32'h0F0F_0F0F ^ 32'(i));
    end_din();
    wait_done("flush_next", 1'b0);

    // Overflow and counter wrap: fill FIFO with two blocks, inject an extra one.
    base = req_log.size();
    start_msg(32'hFFFF_FFFF);
    repeat (50) @(negedge clk);
    #2;
    chk("wrap_nreq", 32'(req_log.size() - base), 32'd2);
    if (req_log.size() >= base + 2) begin
      chk("wrap_req1", req_log[base], 32'hFFFF_FFFF);
      chk("wrap_req2", req_log[base + 1], 32'h0000_0000);
    end
    chk("ovf_before", 32'(ks_ovf), 32'd0);
    for (int k = 0; k < 16; k++) pend.push_back(32'hDEAD_0000 | 32'(k));
    repeat (25) @(negedge clk);
    #2;
    chk("ovf_set", 32'(ks_ovf), 32'd1);
    for (int i = 0; i < 32; i++) begin
      d = 32'h5555_AAAA ^ (32'(i) << 4);
      drive_word(d, 4'hF, (i == 31), exp_word(32'hFFFF_FFFF, i, d, 4'hF));
    end
    end_din();
    wait_done("ovf", 1'b0);
    chk("ovf_sticky", 32'(ks_ovf), 32'd1);

    // Reset mid-message with a word held in the output register.
    sink_stall = 1'b1;
    start_msg(32'd9);
    drive_word(32'hCAFE_F00D, 4'hF, 1'b0, exp_word(32'd9, 0, 32'hCAFE_F00D, 4'hF));
    end_din();
    repeat (3) @(negedge clk);
    #2;
    chk("rst_pre_dout_valid", 32'(dif.dout_valid), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #2;
    chk_reset_outputs("midrst");
    sb.delete();
    pend.delete();
    @(negedge clk);
    rst        = 1'b0;
    sink_stall = 1'b0;
    seen       = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      #1;
      if (done) seen = 1'b1;
    end
    chk("midrst_no_done", 32'(seen), 32'd0);
    chk("midrst_ovf_clear", 32'(ks_ovf), 32'd0);
    chk("end_sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
